bg_ctrl: RTL and testbench
==========================

BG_CTRL -- requirements
Module: bg_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 64: clock cycles between pwrup assertion and the first chop phase.
REQ-002 Parameter PHASE_CYCLES, default 8: length of each chop phase (A and B) in cycles; legal range >=1.
REQ-003 Parameter NOV_CYCLES, default 1: non-overlap gap after each phase in cycles; legal range >=1.
REQ-004 clk  in  1  sole clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level request to power up and run the bandgap chop sequence.
REQ-007 cfg_valid  in  1 / cfg_ready  out  1  valid/ready handshake for a trim word.
REQ-008 cfg_fine  in  8 / cfg_coarse  in  8 / cfg_outsel_n  in  4 / cfg_stable  in  1  trim word fields.
REQ-009 pwrup  out  1  IDAC power-up.
REQ-010 idacFine  out  8 / idacCoarse  out  8 / idacOutSelect_n  out  4  applied IDAC trim.
REQ-011 diodeSelect  out  8 / resStableSelect  out  1 / resPtatEnable_n  out  1  diode DAC controls.
REQ-012 c1  out  2 / c2  out  2  switched-capacitor cell switches (bit0 = CA, bit1 = CB).
REQ-013 ready  out  1  high once settling is complete and chopping is running.
REQ-014 phase_b  out  1  high during PH_B, for downstream demodulation.

Function
REQ-015 States: OFF, SETTLE, PH_A, NOV_A, PH_B, NOV_B.
REQ-016 OFF: pwrup=0, c1=c2=00, diodeSelect=00, resPtatEnable_n=1, ready=0.
REQ-017 Transition OFF->SETTLE on enable=1; SETTLE drives pwrup=1 and all switches open.
REQ-018 SETTLE->PH_A after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-019 PH_A: c1=01, c2=10, diodeSelect=8'h01, resPtatEnable_n=0; lasts PHASE_CYCLES cycles, then NOV_A.
REQ-020 NOV_A and NOV_B: c1=c2=00, diodeSelect held from the preceding phase; each lasts NOV_CYCLES cycles.
REQ-021 NOV_A->PH_B; PH_B: c1=10, c2=01, diodeSelect=8'hFF, phase_b=1; lasts PHASE_CYCLES cycles, then NOV_B->PH_A.
REQ-022 c1 and c2 SHALL never both have any bit set in the same cycle; every phase change passes through all-open.
REQ-023 ready rises on the first PH_A cycle and stays high until the sequencer leaves the chop loop.
REQ-024 enable=0 in any state moves to OFF on the next cycle, including mid-SETTLE and mid-phase; no phase completion is required.
REQ-025 A single shadow register holds a pending trim word; cfg_ready = !pending.
REQ-026 A trim word is accepted when cfg_valid && cfg_ready in that cycle.
REQ-027 A pending word is applied to the idac*/resStableSelect outputs in the cycle after acceptance when in OFF, or on the NOV_B->PH_A transition otherwise; pending clears in that same cycle.
REQ-028 If acceptance and apply coincide, the newly accepted word waits for the next boundary; the applied word is the older one.
REQ-029 Applied trim is retained across OFF and re-enable; only reset clears it.
REQ-030 Phase and settle counters SHALL be sized $clog2(max param)+1 and SHALL reset to 0 on every state entry; they never wrap.

Reset
REQ-031 On reset: state=OFF, pending=0, cfg_ready=1, idacFine=8'h80, idacCoarse=8'h80, idacOutSelect_n=4'b1101 (IOUT only), resStableSelect=0, and all other outputs at their OFF values.
REQ-032 Reset has priority over enable and over cfg handshakes in the same cycle.

Structure
REQ-033 A shared package bg_pkg SHALL hold the state enum, the trim-word struct, and the constants DIODE_1X=8'h01, DIODE_NX=8'hFF, and the trim reset values.
REQ-034 One sub-module, bg_trim_shadow, SHALL implement the REQ-025..REQ-029 shadow/apply logic; the FSM stays in bg_ctrl.

Verification
REQ-035 Reset, then enable=1 -> pwrup=1 the next cycle, ready=1 exactly SETTLE_CYCLES cycles later, with c1=01 and c2=10 at that point.
REQ-036 Free-run 100 periods with defaults -> period = 2*(8+1) = 18 cycles, no cycle with c1&c2 overlap, and diodeSelect alternating 01/FF.
REQ-037 Trim word fine=8'h3C, coarse=8'h11 sent mid-PH_A -> cfg_ready=0 until NOV_B->PH_A, outputs update exactly at that edge, then cfg_ready=1.
REQ-038 Trim word sent in OFF -> applied the next cycle; a second word sent on the apply cycle -> held and applied on the following boundary.
REQ-039 enable dropped mid-PH_B -> next cycle OFF with all switches 00, pwrup=0, ready=0; re-enable -> full SETTLE_CYCLES repeated.
REQ-040 reset asserted mid-SETTLE together with cfg_valid -> OFF state, trim values at their reset defaults, and no word accepted.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared types and constants for the bandgap chop controller.
// Holds the sequencer state encoding, the IDAC trim word and its reset value.
package bg_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_PH_A,
    ST_NOV_A,
    ST_PH_B,
    ST_NOV_B
  } bg_state_e;

  typedef struct packed {
    logic [7:0] fine;
    logic [7:0] coarse;
    logic [3:0] outsel_n;
    logic       stable;
  } bg_trim_t;

  localparam logic [7:0] DIODE_OFF = 8'h00;
  localparam logic [7:0] DIODE_1X  = 8'h01;
  localparam logic [7:0] DIODE_NX  = 8'hFF;

  localparam logic [7:0] TRIM_FINE_RST   = 8'h80;
  localparam logic [7:0] TRIM_COARSE_RST = 8'h80;
  localparam logic [3:0] TRIM_OUTSEL_RST = 4'b1101;
  localparam logic       TRIM_STABLE_RST = 1'b0;

  localparam bg_trim_t TRIM_RESET = '{
    fine:     TRIM_FINE_RST,
    coarse:   TRIM_COARSE_RST,
    outsel_n: TRIM_OUTSEL_RST,
    stable:   TRIM_STABLE_RST
  };

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bg_trim_shadow.sv
// Single-entry shadow register for IDAC trim words; a pending word is applied
// immediately while powered down, otherwise only at the start of a chop period.
module bg_trim_shadow
  import bg_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     cfg_valid,
  input  bg_trim_t cfg_word,
  input  logic     apply_off,
  input  logic     apply_boundary,
  output logic     cfg_ready,
  output bg_trim_t trim
);

  logic     pending_reg;
  bg_trim_t shadow_reg;
  bg_trim_t trim_reg;
  logic     accept;
  logic     apply;

  assign cfg_ready = !pending_reg;
  assign accept    = cfg_valid && !pending_reg;
  assign apply     = pending_reg && (apply_off || apply_boundary);
  assign trim      = trim_reg;

  // Apply always takes the older shadow contents; a word accepted on the same
  // edge stays pending for the next apply opportunity.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      shadow_reg  <= TRIM_RESET;
      trim_reg    <= TRIM_RESET;
    end else begin
      if (apply) begin
        trim_reg <= shadow_reg;
      end
      if (accept) begin
        shadow_reg <= cfg_word;
      end
      pending_reg <= accept || (pending_reg && !apply);
    end
  end

endmodule

// File: rtl/bg_ctrl.sv
// Bandgap power-up and chop sequencer: OFF -> SETTLE -> PH_A/NOV_A/PH_B/NOV_B loop,
// with break-before-make switching and a shadowed IDAC trim interface.
module bg_ctrl
  import bg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int PHASE_CYCLES  = 8,
  parameter int NOV_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_fine,
  input  logic [7:0] cfg_coarse,
  input  logic [3:0] cfg_outsel_n,
  input  logic       cfg_stable,
  output logic       pwrup,
  output logic [7:0] idacFine,
  output logic [7:0] idacCoarse,
  output logic [3:0] idacOutSelect_n,
  output logic [7:0] diodeSelect,
  output logic       resStableSelect,
  output logic       resPtatEnable_n,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic       ready,
  output logic       phase_b
);

  localparam int MAX_CYC = max3(SETTLE_CYCLES, PHASE_CYCLES, NOV_CYCLES);
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] PHASE_LAST  = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] NOV_LAST    = CW'(NOV_CYCLES - 1);

  bg_state_e     state_reg;
  bg_state_e     state_next;
  logic [CW-1:0] cnt_reg;
  logic          apply_boundary;
  bg_trim_t      cfg_word;
  bg_trim_t      trim;

  // Counter restarts on every state change and is parked in OFF so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_OFF;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_next != state_reg) || (state_reg == ST_OFF)) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF:    if (enable) state_next = ST_SETTLE;
      ST_SETTLE: if (cnt_reg == SETTLE_LAST) state_next = ST_PH_A;
      ST_PH_A:   if (cnt_reg == PHASE_LAST) state_next = ST_NOV_A;
      ST_NOV_A:  if (cnt_reg == NOV_LAST) state_next = ST_PH_B;
      ST_PH_B:   if (cnt_reg == PHASE_LAST) state_next = ST_NOV_B;
      ST_NOV_B:  if (cnt_reg == NOV_LAST) state_next = ST_PH_A;
      default:   state_next = ST_OFF;
    endcase
    if (!enable) begin
      state_next = ST_OFF;
    end
  end

  assign apply_boundary = (state_reg == ST_NOV_B) && (state_next == ST_PH_A);

  always_comb begin
    pwrup           = 1'b0;
    ready           = 1'b0;
    phase_b         = 1'b0;
    c1              = 2'b00;
    c2              = 2'b00;
    diodeSelect     = DIODE_OFF;
    resPtatEnable_n = 1'b1;
    case (state_reg)
      ST_SETTLE: begin
        pwrup = 1'b1;
      end
      ST_PH_A: begin
        pwrup           = 1'b1;
        ready           = 1'b1;
        c1              = 2'b01;
        c2              = 2'b10;
        diodeSelect     = DIODE_1X;
        resPtatEnable_n = 1'b0;
      end
      ST_NOV_A: begin
        pwrup           = 1'b1;
        ready           = 1'b1;
        diodeSelect     = DIODE_1X;
        resPtatEnable_n = 1'b0;
      end
      ST_PH_B: begin
        pwrup           = 1'b1;
        ready           = 1'b1;
        phase_b         = 1'b1;
        c1              = 2'b10;
        c2              = 2'b01;
        diodeSelect     = DIODE_NX;
        resPtatEnable_n = 1'b0;
      end
      ST_NOV_B: begin
        pwrup           = 1'b1;
        ready           = 1'b1;
        diodeSelect     = DIODE_NX;
        resPtatEnable_n = 1'b0;
      end
      default: begin
        pwrup = 1'b0;
      end
    endcase
  end

  assign cfg_word = {cfg_fine, cfg_coarse, cfg_outsel_n, cfg_stable};

  bg_trim_shadow u_trim_shadow (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_word       (cfg_word),
    .apply_off      (state_reg == ST_OFF),
    .apply_boundary (apply_boundary),
    .cfg_ready      (cfg_ready),
    .trim           (trim)
  );

  assign idacFine        = trim.fine;
  assign idacCoarse      = trim.coarse;
  assign idacOutSelect_n = trim.outsel_n;
  assign resStableSelect = trim.stable;

endmodule

// File: tb/tb_bg_ctrl.sv
// Self-checking bench for bg_ctrl: sequencer timing, switch non-overlap and the
// trim shadow, with applied trim words tracked through a scoreboard queue.
module tb_bg_ctrl;

  localparam int SETTLE = 64;
  localparam int PHASE  = 8;
  localparam int NOV    = 1;
  localparam int PER    = 2 * (PHASE + NOV);

  localparam logic [20:0] TRIM_DEF = {8'h80, 8'h80, 4'b1101, 1'b0};
  localparam logic [20:0] W_OFF1   = {8'hA5, 8'h5A, 4'b0011, 1'b1};
  localparam logic [20:0] W_OFF2   = {8'h12, 8'h34, 4'b1110, 1'b0};
  localparam logic [20:0] W_A      = {8'h3C, 8'h11, 4'b0110, 1'b1};
  localparam logic [20:0] W_B      = {8'hC3, 8'h7E, 4'b0111, 1'b0};

  logic       clk, reset, enable, cfg_valid, cfg_ready, cfg_stable;
  logic [7:0] cfg_fine, cfg_coarse;
  logic [3:0] cfg_outsel_n;
  logic       pwrup, resStableSelect, resPtatEnable_n, ready, phase_b;
  logic [7:0] idacFine, idacCoarse, diodeSelect;
  logic [3:0] idacOutSelect_n;
  logic [1:0] c1, c2;

  bg_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .PHASE_CYCLES  (PHASE),
    .NOV_CYCLES    (NOV)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_fine        (cfg_fine),
    .cfg_coarse      (cfg_coarse),
    .cfg_outsel_n    (cfg_outsel_n),
    .cfg_stable      (cfg_stable),
    .pwrup           (pwrup),
    .idacFine        (idacFine),
    .idacCoarse      (idacCoarse),
    .idacOutSelect_n (idacOutSelect_n),
    .diodeSelect     (diodeSelect),
    .resStableSelect (resStableSelect),
    .resPtatEnable_n (resPtatEnable_n),
    .c1              (c1),
    .c2              (c2),
    .ready           (ready),
    .phase_b         (phase_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] word;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks, errors, cyc, t0;
  bit          in_chop;
  logic [20:0] prev_trim, pend_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [20:0] trim_out();
    return {idacFine, idacCoarse, idacOutSelect_n, resStableSelect};
  endfunction

  // {pwrup, ready, phase_b, c1, c2, diodeSelect, resPtatEnable_n}
  function automatic logic [15:0] out_vec();
    return {pwrup, ready, phase_b, c1, c2, diodeSelect, resPtatEnable_n};
  endfunction

  // 0 OFF, 1 SETTLE, 2 PH_A, 3 NOV_A, 4 PH_B, 5 NOV_B
  function automatic logic [15:0] exp_vec(input int st);
    case (st)
      1:       return {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1};
      2:       return {1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 8'h01, 1'b0};
      3:       return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 8'h01, 1'b0};
      4:       return {1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 8'hFF, 1'b0};
      5:       return {1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 8'hFF, 1'b0};
      default: return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1};
    endcase
  endfunction

  // Fields the requirements leave open in a state are masked out.
  function automatic logic [15:0] exp_mask(input int st);
    case (st)
      0, 2:    return 16'hFFFF;
      1:       return 16'hFE00;
      default: return 16'hFFFE;
    endcase
  endfunction

  function automatic int chop_state(input int k);
    if (k < PHASE) return 2;
    if (k < PHASE + NOV) return 3;
    if (k < 2 * PHASE + NOV) return 4;
    return 5;
  endfunction

  task automatic chk_state(input string tag, input int st);
    logic [15:0] m;
    m = exp_mask(st);
    chk(tag, 32'(out_vec() & m), 32'(exp_vec(st) & m));
    chk({tag, "_overlap"}, 32'(c1 & c2), 32'h0);
  endtask

  task automatic send(input logic [20:0] w);
    pend_word = w;
    {cfg_fine, cfg_coarse, cfg_outsel_n, cfg_stable} = w;
    cfg_valid = 1'b1;
  endtask

  // One clock: handshake bookkeeping, scoreboard pop on trim change, cfg_ready check.
  task automatic step();
    bit          acc;
    int          k;
    exp_t        e;
    logic [20:0] cur;
    acc = cfg_valid && !reset && (sb_q.size() == 0);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      e.word = pend_word;
      if (in_chop) begin
        k = (cyc - t0) % PER;
        e.due = cyc + ((k == 0) ? PER : PER - k);
      end else begin
        e.due = cyc + 1;
      end
      sb_q.push_back(e);
      cfg_valid = 1'b0;
      $display("accept word %h at cycle %0d, apply due %0d", e.word, cyc, e.due);
    end
    cur = trim_out();
    if (cur !== prev_trim) begin
      if (sb_q.size() == 0) begin
        chk("trim_unexpected", 32'(cur), 32'(prev_trim));
      end else begin
        e = sb_q.pop_front();
        chk("trim_value", 32'(cur), 32'(e.word));
        chk("trim_cycle", cyc, e.due);
        $display("apply word %h at cycle %0d", cur, cyc);
      end
      prev_trim = cur;
    end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
      e = sb_q.pop_front();
      chk("trim_late", 32'(cur), 32'(e.word));
    end
    chk("cfg_ready", 32'(cfg_ready), 32'(sb_q.size() == 0));
  endtask

  task automatic settle_seq();
    int t_en;
    t_en   = cyc;
    enable = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin
      step();
      chk_state("settle", 1);
    end
    step();
    chk_state("first_ph_a", 2);
    chk("ready_latency", cyc - t_en, SETTLE + 1);
    t0      = cyc;
    in_chop = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; t0 = 0; in_chop = 1'b0;
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_fine = '0; cfg_coarse = '0; cfg_outsel_n = '0; cfg_stable = 1'b0;
    pend_word = '0;
    prev_trim = TRIM_DEF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_state("reset_outputs", 0);
    chk("reset_trim", 32'(trim_out()), 32'(TRIM_DEF));
    chk("reset_cfg_ready", 32'(cfg_ready), 32'h1);

    // Trim in OFF, second word offered on the apply cycle
    send(W_OFF1);
    step(); chk_state("off_cfg", 0);
    send(W_OFF2);
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("off_cfg", 0);
    end
    chk("off_queue_empty", sb_q.size(), 0);

    // Power-up, then free-run with trim words mid-PH_A and on a boundary edge
    settle_seq();
    for (int i = 1; i <= 100 * PER; i++) begin
      if (i == 2 * PER + 3) send(W_A);
      if (i == 10 * PER) send(W_B);
      step();
      chk_state("chop", chop_state(i % PER));
    end

    // Drop enable mid-PH_B
    for (int i = 1; i <= PHASE + NOV + 3; i++) begin
      step();
      chk_state("chop_tail", chop_state(i % PER));
    end
    enable = 1'b0;
    step();
    in_chop = 1'b0;
    chk_state("drop_off", 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("stay_off", 0);
    end
    chk("chop_queue_empty", sb_q.size(), 0);

    // Re-enable repeats the full settle time
    settle_seq();
    for (int i = 1; i <= PER; i++) begin
      step();
      chk_state("rerun", chop_state(i % PER));
    end

    // Reset mid-SETTLE with a trim word offered
    enable = 1'b0;
    step(); in_chop = 1'b0; chk_state("pre_rst_off", 0);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); chk_state("pre_rst_settle", 1);
    end
    reset = 1'b1;
    send(W_A);
    @(posedge clk);
    #1;
    cyc++;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    enable    = 1'b0;
    chk_state("rst_off", 0);
    chk("rst_trim", 32'(trim_out()), 32'(TRIM_DEF));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    prev_trim = TRIM_DEF;
    for (int i = 0; i < 4; i++) begin
      step(); chk_state("post_rst_off", 0);
    end
    chk("final_queue_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
